// File: rtl/ser_pkg.sv
// Shared types for the parallel-in/serial-out stage feeding the "1001" detector.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  function automatic int ser_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Streams WIDTH-bit words out one bit per clock with valid/ready intake, hold and a per-word done pulse.
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             hold,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             done
);

  localparam int            CW   = ser_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             done_q;
  logic             last_bit;
  logic             accept;

  // The last-bit cycle doubles as an intake slot so consecutive words run gap-free.
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST) && !hold;
  assign load_ready = rst_n && ((state_q == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;

  assign sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  assign cnt_d  = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sreg_q  <= load_data;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!hold) begin
            if (cnt_q == LAST) begin
              done_q <= 1'b1;
              if (accept) begin
                sreg_q <= load_data;
                cnt_q  <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              sreg_q <= sreg_d;
              cnt_q  <= cnt_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Idle drives zeros so the downstream detector never sees stale word bits.
  assign bit_out   = (state_q == SHIFT) ? (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]) : 1'b0;
  assign bit_valid = (state_q == SHIFT);
  assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: MSB-first and LSB-first serializers, each feeding a "1001" detector model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lv_a, lv_b;
  logic [7:0] data_i;
  logic       hold;
  logic       lr_a, bo_a, bv_a, dn_a;
  logic       lr_b, bo_b, bv_b, dn_b;
  logic [3:0] hist_a, hist_b;
  logic       y_a, y_b;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_a), .load_data(data_i), .load_ready(lr_a),
    .hold(hold), .bit_out(bo_a), .bit_valid(bv_a), .done(dn_a)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(lv_b), .load_data(data_i), .load_ready(lr_b),
    .hold(hold), .bit_out(bo_b), .bit_valid(bv_b), .done(dn_b)
  );

  // Detector model: rst = !rst_n, y high the cycle after the last bit of "1001" is clocked in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_a <= '0;
      hist_b <= '0;
    end else begin
      hist_a <= {hist_a[2:0], bo_a};
      hist_b <= {hist_b[2:0], bo_b};
    end
  end
  assign y_a = (hist_a == 4'b1001);
  assign y_b = (hist_b == 4'b1001);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic cyc(input string tag, input bit sel, input logic bv, input logic bo,
                     input logic lr, input logic dn);
    if (!sel) begin
      chk({tag, ".bit_valid"}, bv_a, bv);
      chk({tag, ".bit_out"}, bo_a, bo);
      chk({tag, ".load_ready"}, lr_a, lr);
      chk({tag, ".done"}, dn_a, dn);
    end else begin
      chk({tag, ".bit_valid"}, bv_b, bv);
      chk({tag, ".bit_out"}, bo_b, bo);
      chk({tag, ".load_ready"}, lr_b, lr);
      chk({tag, ".done"}, dn_b, dn);
    end
  endtask

  // One word; expbits lists the bit seen each cycle (first cycle in the MSB of the n-bit field).
  task automatic word1(input string tag, input bit sel, input logic [7:0] data,
                       input logic [15:0] expbits, input int n, input int hs, input int he,
                       input bit chky);
    logic [15:0] eb;
    eb = expbits;
    data_i = data;
    if (sel) lv_b = 1'b1; else lv_a = 1'b1;
    #1;
    chk({tag, " idle.load_ready"}, sel ? lr_b : lr_a, 1'b1);
    tick();
    lv_a = 1'b0;
    lv_b = 1'b0;
    data_i = 8'h00;
    for (int c = 0; c < n; c++) begin
      hold = (c >= hs) && (c <= he);
      #1;
      cyc($sformatf("%s c%0d", tag, c), sel, 1'b1, eb[n-1-c], (c == n - 1), 1'b0);
      if (chky) chk($sformatf("%s c%0d.y", tag, c), sel ? y_b : y_a, (c == 4));
      tick();
    end
    hold = 1'b0;
    #1;
    cyc({tag, " done"}, sel, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk({tag, " after.done"}, sel ? dn_b : dn_a, 1'b0);
  endtask

  // Two words on DUT A; the second word's valid rises at cycle lvstart of the first word.
  task automatic stream2(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                         input int lvstart);
    logic [15:0] s;
    s = {w0, w1};
    data_i = w0;
    lv_a = 1'b1;
    tick();
    data_i = w1;
    lv_a = (lvstart == 0);
    for (int j = 0; j < 16; j++) begin
      if (j == lvstart) lv_a = 1'b1;
      if (j == 8) lv_a = 1'b0;
      #1;
      cyc($sformatf("%s j%0d", tag, j), 1'b0, 1'b1, s[15-j], (j == 7) || (j == 15), (j == 8));
      tick();
    end
    #1;
    cyc({tag, " done"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk({tag, " after.done"}, dn_a, 1'b0);
  endtask

  initial begin
    rst_n  = 1'b0;
    lv_a   = 1'b0;
    lv_b   = 1'b0;
    data_i = 8'h00;
    hold   = 1'b0;
    tick();
    tick();
    cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.b.load_ready", lr_b, 1'b0);
    rst_n = 1'b1;
    #1;
    cyc("post_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();

    word1("w90_msb", 1'b0, 8'b1001_0000, 16'b1001_0000, 8, 99, -1, 1'b1);
    stream2("a5_3c", 8'hA5, 8'h3C, 0);
    word1("f0_hold", 1'b0, 8'hF0, 16'b111_1111_0000, 11, 2, 4, 1'b0);
    word1("w09_lsb", 1'b1, 8'b0000_1001, 16'b1001_0000, 8, 99, -1, 1'b1);

    // Asynchronous reset three bits into 0xFF.
    data_i = 8'hFF;
    lv_a = 1'b1;
    tick();
    lv_a = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      cyc($sformatf("ff c%0d", c), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    cyc("ff async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    cyc("ff released", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    cyc("ff no_done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    word1("w81", 1'b0, 8'h81, 16'b1000_0001, 8, 99, -1, 1'b0);

    stream2("c3_55", 8'hC3, 8'h55, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
